// File: rtl/cass_capture.sv
// Cassette-output decoder: recovers Level II 500-baud cells from port-FF writes and frames bytes into a FIFO.
// Optional macro CASS_SYNC_HUNT_EN: frame on SYNC_BYTE; otherwise push raw bytes from block start.
module cass_capture #(
    parameter int unsigned CLK_MHZ      = 28,
    parameter int unsigned SHORT_MAX_US = 1400,
    parameter int unsigned TIMEOUT_US   = 4000,
    parameter int unsigned FIFO_DEPTH   = 16
`ifdef CASS_SYNC_HUNT_EN
    ,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cass_we,
    input  logic [1:0]                  cass_data,
    input  logic                        motor,
    input  logic                        rd_en,
    input  logic                        clr,
    output logic [7:0]                  rd_data,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        locked,
    output logic                        overflow
);

    localparam int unsigned PRE_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int unsigned INT_W = 13;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CLK  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [PRE_W-1:0] presc;
    logic [INT_W-1:0] interval;
    logic [1:0]       prev_data;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       mem [FIFO_DEPTH];

    logic             tick_c;
    logic             pulse_c;
    logic             timeout_c;
    logic             short_c;
    logic             emit_c;
    logic             emit_bit_c;
    logic             idle_next_c;
    logic [7:0]       shift_next_c;
    logic             push_c;
    logic             pop_c;
    logic             full_c;
    logic             wr_c;
    logic [LVL_W-1:0] level_next_c;

    // Pulse = rising entry into the 2'b01 output value; interval counts whole microseconds.
    assign tick_c    = (presc == PRE_W'(CLK_MHZ - 1));
    assign pulse_c   = cass_we && (cass_data == 2'b01) && (prev_data != 2'b01);
    assign timeout_c = tick_c && !pulse_c && (interval == INT_W'(TIMEOUT_US - 1));
    assign short_c   = (interval < INT_W'(SHORT_MAX_US));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            interval  <= '0;
            prev_data <= 2'b00;
        end else begin
            presc <= tick_c ? '0 : presc + PRE_W'(1);
            if (cass_we) begin
                prev_data <= cass_data;
            end
            if (pulse_c) begin
                interval <= '0;
            end else if (tick_c && (interval != '1)) begin
                interval <= interval + INT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Cell decoder: a short clock-to-pulse gap is a data pulse (bit 1), a long one is the next clock (bit 0).
    always_comb begin
        state_next = state;
        emit_c     = 1'b0;
        emit_bit_c = 1'b0;
        if (clr || !motor) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pulse_c) begin
                        state_next = ST_CLK;
                    end
                end
                ST_CLK: begin
                    if (pulse_c) begin
                        emit_c = 1'b1;
                        if (short_c) begin
                            emit_bit_c = 1'b1;
                            state_next = ST_DATA;
                        end
                    end else if (timeout_c) begin
                        emit_c     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (pulse_c) begin
                        state_next = ST_CLK;
                    end else if (timeout_c) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign idle_next_c  = (state_next == ST_IDLE);
    assign shift_next_c = {shift[6:0], emit_bit_c};

`ifdef CASS_SYNC_HUNT_EN
    assign push_c = emit_c && locked && (bit_cnt == 3'd7);
`else
    assign push_c = emit_c && (bit_cnt == 3'd7);
`endif

    // Byte framing; the final timeout bit still pushes before the block state is cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift   <= 8'h00;
            bit_cnt <= 3'd0;
            locked  <= 1'b0;
        end else if (idle_next_c) begin
            shift   <= 8'h00;
            bit_cnt <= 3'd0;
            locked  <= 1'b0;
        end else if (emit_c) begin
            shift <= shift_next_c;
`ifdef CASS_SYNC_HUNT_EN
            if (!locked) begin
                if (shift_next_c == SYNC_BYTE) begin
                    locked  <= 1'b1;
                    bit_cnt <= 3'd0;
                end
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
            end
`else
            locked  <= 1'b1;
            bit_cnt <= bit_cnt + 3'd1;
`endif
        end
    end

    // Byte FIFO; a simultaneous pop frees the slot so a push at full is not dropped.
    assign full_c = (level == LVL_W'(FIFO_DEPTH));
    assign pop_c  = rd_en && !empty;
    assign wr_c   = push_c && (!full_c || pop_c);

    always_comb begin
        level_next_c = level;
        case ({wr_c, pop_c})
            2'b10:   level_next_c = level + LVL_W'(1);
            2'b01:   level_next_c = level - LVL_W'(1);
            default: level_next_c = level;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next_c;
            empty <= (level_next_c == '0);
            if (push_c && !wr_c) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c && !clr) begin
            mem[wr_ptr] <= shift_next_c;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (!empty) begin
            rd_data = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_cass_capture.sv
// Randomized bench for cass_capture: sends cassette blocks with jittered pulse timing, predicts FIFO contents per block.
module tb_cass_capture;

    localparam int unsigned CLK_MHZ    = 4;
    localparam int unsigned SHORT_US   = 14;
    localparam int unsigned TIMEOUT_US = 40;
    localparam int unsigned DEPTH      = 16;
`ifdef CASS_SYNC_HUNT_EN
    localparam bit HUNT = 1'b1;
`else
    localparam bit HUNT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cass_we = 1'b0;
    logic [1:0] cass_data = 2'b00;
    logic       motor = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic [4:0] level;
    logic       locked;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] blk [$];
    logic [7:0] mq  [$];
    bit         movf = 1'b0;
    bit         mlocked = 1'b0;
    int         start_idx;
    int         pop_byte;

    cass_capture #(
        .CLK_MHZ     (CLK_MHZ),
        .SHORT_MAX_US(SHORT_US),
        .TIMEOUT_US  (TIMEOUT_US),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cass_we  (cass_we),
        .cass_data(cass_data),
        .motor    (motor),
        .rd_en    (rd_en),
        .clr      (clr),
        .rd_data  (rd_data),
        .empty    (empty),
        .level    (level),
        .locked   (locked),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic silence(input int us);
        repeat (us * CLK_MHZ) @(negedge clk);
    endtask

    // Gap measured from the start of the previous pulse, which itself occupies 4 cycles.
    task automatic gap(input int us);
        repeat (us * CLK_MHZ - 4) @(negedge clk);
    endtask

    // Level II style write burst: 01, then 10 (or a repeated 01 that must not retrigger), then 00.
    task automatic pulse(input bit pop);
        cass_we   = 1'b1;
        cass_data = 2'b01;
        rd_en     = pop;
        @(negedge clk);
        rd_en     = 1'b0;
        cass_data = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        @(negedge clk);
        cass_data = 2'b00;
        @(negedge clk);
        cass_we   = 1'b0;
        @(negedge clk);
    endtask

    function automatic bit bit_at(input int i);
        logic [7:0] b;
        b = blk[i / 8];
        return b[7 - (i % 8)];
    endfunction

    // One clock pulse per cell; a 1 adds a data pulse after a short gap, a 0 waits a long gap.
    task automatic send_bits(input int nbits, input int pop_bit);
        for (int i = 0; i < nbits; i++) begin
            pulse(1'b0);
            if (bit_at(i)) begin
                gap($urandom_range(6, 12));
                pulse(i == pop_bit);
                if (i != nbits - 1) gap($urandom_range(4, 12));
            end else if (i != nbits - 1) begin
                gap($urandom_range(16, 30));
            end
        end
    endtask

    // Byte-level prediction: with sync hunting, bytes after the first sync byte are stored; otherwise all bytes.
    task automatic model_block(input int nfull, input int pop_at);
        bit found;
        int start;
        found = 1'b0;
        start = 0;
        if (HUNT) begin
            start = nfull;
            for (int k = 0; k < nfull; k++) begin
                if (blk[k] == 8'hA5) begin
                    found = 1'b1;
                    start = k + 1;
                    break;
                end
            end
        end
        for (int j = start; j < nfull; j++) begin
            if (j == pop_at && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() < DEPTH) mq.push_back(blk[j]);
            else movf = 1'b1;
        end
        mlocked = HUNT ? found : 1'b1;
    endtask

    task automatic drain(input string tag);
        check({tag, "_level"}, 32'(level), 32'(mq.size()));
        check({tag, "_ovf"}, 32'(overflow), 32'(movf));
        check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        while (mq.size() > 0) begin
            check({tag, "_data"}, 32'(rd_data), 32'(mq.pop_front()));
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        check({tag, "_empty_end"}, 32'(empty), 32'd1);
        check({tag, "_rd0_end"}, 32'(rd_data), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        mq.delete();
        movf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with rd_en held high and no pulses
        motor = 1'b1;
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_level", 32'(level), 32'd0);
        check("idle_locked", 32'(locked), 32'd0);
        check("idle_rd_data", 32'(rd_data), 32'd0);
        check("idle_ovf", 32'(overflow), 32'd0);
        rd_en = 1'b0;

        // A: 16-byte leader, sync, 3C FF
        blk.delete();
        repeat (16) blk.push_back(8'h00);
        blk.push_back(8'hA5);
        blk.push_back(8'h3C);
        blk.push_back(8'hFF);
        send_bits(blk.size() * 8, -1);
        model_block(blk.size(), -1);
        silence(20);
        check("A_locked_hold", 32'(locked), 32'(mlocked));
        silence(30);
        check("A_locked_drop", 32'(locked), 32'd0);
        drain("A");
        do_clr();

        // B: final zero bit flushed by timeout
        blk.delete();
        blk.push_back(8'h00);
        blk.push_back(8'hA5);
        blk.push_back(8'hFE);
        send_bits(blk.size() * 8, -1);
        model_block(blk.size(), -1);
        silence(60);
        check("B_locked", 32'(locked), 32'd0);
        drain("B");
        do_clr();

        // C: overflow, then clr
        blk.delete();
        blk.push_back(8'h00);
        blk.push_back(8'hA5);
        repeat (17) blk.push_back(8'($urandom()));
        send_bits(blk.size() * 8, -1);
        model_block(blk.size(), -1);
        silence(60);
        check("C_level", 32'(level), 32'(mq.size()));
        check("C_ovf", 32'(overflow), 32'(movf));
        check("C_head", 32'(rd_data), 32'(mq[0]));
        do_clr();
        check("C_clr_level", 32'(level), 32'd0);
        check("C_clr_ovf", 32'(overflow), 32'd0);
        check("C_clr_empty", 32'(empty), 32'd1);
        check("C_clr_rd0", 32'(rd_data), 32'd0);

        // D: 17th push coincides with a pop while full
        start_idx = HUNT ? 2 : 0;
        pop_byte  = start_idx + DEPTH;
        blk.delete();
        blk.push_back(8'h00);
        blk.push_back(8'hA5);
        while (blk.size() < pop_byte) blk.push_back(8'($urandom()));
        blk.push_back(8'($urandom()) | 8'h01);
        send_bits(blk.size() * 8, pop_byte * 8 + 7);
        model_block(blk.size(), pop_byte);
        silence(60);
        check("D_level_full", 32'(level), 32'(DEPTH));
        drain("D");
        do_clr();

        // E: motor dropped five bits into a byte
        blk.delete();
        blk.push_back(8'h00);
        blk.push_back(8'hA5);
        blk.push_back(8'($urandom()));
        send_bits(2 * 8 + 5, -1);
        model_block(2, -1);
        silence(5);
        check("E_locked_pre", 32'(locked), 32'(mlocked));
        motor = 1'b0;
        repeat (2) @(negedge clk);
        check("E_locked_drop", 32'(locked), 32'd0);
        silence(60);
        motor = 1'b1;
        repeat (4) @(negedge clk);
        drain("E");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cass_capture.md
# cass_capture

Cassette-output decoder for the TRS-80 core. It watches the CPU's port-FF cassette writes and recovers the Level II 500-baud bit stream, a clock pulse plus an optional data pulse per cell. It frames bytes on the A5 sync byte and buffers them in a FIFO so the ESP32 SPI path can drain CSAVE output from the FPGA. It sits beside the tape_bits / audio logic in the top level and runs in the cpuClock domain.

## Interface
- CLK_MHZ, 28: clk frequency in MHz; also the prescaler count for 1 µs ticks.
- SHORT_MAX_US, 1400: an inter-pulse interval below this is short, otherwise long.
- TIMEOUT_US, 4000: silence that ends a block.
- FIFO_DEPTH, 16: byte FIFO depth, power of two.
- SYNC_BYTE, 8'hA5: framing byte.
- clk  in  1  cpuClock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cass_we  in  1  one-cycle strobe, high when the CPU writes port FF (already qualified with the CPU clock enable).
- cass_data  in  2  cpuDataOut[1:0] for that write.
- motor  in  1  tape_bits[2]. Low forces IDLE.
- rd_en  in  1  pops the FIFO head. Ignored when empty.
- clr  in  1  synchronous; flushes the FIFO, clears overflow, returns to IDLE.
- rd_data  out  8  FIFO head (first-word fall-through); 8'h00 when empty.
- empty  out  1  FIFO empty.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- locked  out  1  sync found; bytes are being framed.
- overflow  out  1  sticky; set when a byte is dropped.

## Operation
- **Pulse event:** cass_we with cass_data==2'b01 while the previous written value was not 2'b01. The previous value resets to 2'b00.
- **µs counter:** a prescaler ticks every CLK_MHZ cycles. A 13-bit interval counter counts ticks since the last pulse event, saturates at 8191, and clears on each pulse event.
- **Cell FSM states:** IDLE, CLK_SEEN, DATA_SEEN.
  - IDLE + pulse → CLK_SEEN. No bit is emitted.
  - CLK_SEEN + pulse with interval < SHORT_MAX_US → emit bit 1, go to DATA_SEEN.
  - CLK_SEEN + pulse with interval ≥ SHORT_MAX_US → emit bit 0, stay in CLK_SEEN. The new pulse is the next clock.
  - DATA_SEEN + pulse → CLK_SEEN. No bit is emitted.
  - CLK_SEEN + interval reaching TIMEOUT_US → emit bit 0, go to IDLE. This flushes the final zero bit.
  - DATA_SEEN + interval reaching TIMEOUT_US → IDLE.
  - motor low or clr → IDLE immediately. No bit is emitted and the partial byte is discarded.
- **Framing:** bits enter an 8-bit shift register MSB-first.
  - While unlocked, after each emitted bit, if shift==SYNC_BYTE then locked←1 and the bit count is cleared. The sync byte itself is not stored.
  - While locked, every 8th bit pushes the assembled byte.
  - locked clears whenever the FSM enters IDLE.
- **FIFO:**
  - Push when full: the byte is dropped and overflow←1.
  - Push and pop in the same cycle: legal at any level, including full. level is unchanged and nothing is dropped.
- **Reset values:** all state IDLE, counters 0, rd_data 8'h00, empty 1, level 0, locked 0, overflow 0.

## Timing
- Bit decision occurs in the cycle the qualifying cass_we or timeout tick is seen. The shift register and sync compare update the next cycle.
- FIFO push is registered: empty falls and level increments 1 cycle after the byte-completing bit is emitted.
- rd_data is valid combinationally from the head while !empty. rd_en pops at the clock edge, and the next head appears in the following cycle.
- clr has priority over push and pop in the same cycle.
- Asynchronous reset mid-block discards everything. Decoding resumes only after a fresh pulse from IDLE.
- A timeout tick and a pulse in the same cycle: the pulse wins and the timeout is ignored.

## Configuration
- **Macro CASS_SYNC_HUNT_EN:**
  - Defined: framing as above. Bytes before SYNC_BYTE are discarded, and locked reflects sync.
  - Undefined: locked rises on the first emitted bit and every 8 bits are pushed raw from the start of the block, leader included. SYNC_BYTE is unused.

## Test plan
Bench uses CLK_MHZ=4.
- Reset with rd_en=1 and no pulses: empty=1, level=0, locked=0, rd_data=8'h00; rd_en has no effect.
- Leader of 16× 8'h00, then A5, then 8'h3C and 8'hFF (1 ms data spacing, 2 ms cells), then silence: FIFO holds 3C, FF; locked=1 until 4000 µs after the last pulse, then 0.
- Block ending in byte 8'hFE, then silence: the final 0 bit is emitted on timeout and the FIFO head reads FE.
- 17 bytes after sync with no reads: level=16, overflow=1, head is the first byte. clr → level=0, overflow=0, empty=1.
- Full FIFO with push and rd_en in the same cycle: level stays 16 and overflow stays 0.
- motor dropped mid-byte after 5 bits: FSM goes to IDLE, locked=0, nothing is pushed. Build without CASS_SYNC_HUNT_EN: the leader bytes 8'h00 appear in the FIFO.
